// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (non-restoring).
// Optional fast zero-operand completion: `define MULTDIV_FAST_EXC_EN.
//
// Ports:
//   clock, reset (async, active low)
//   ctrl_MULT, ctrl_DIV        : one-cycle start strobes (MULT wins)
//   data_operandA/B [WIDTH]    : sampled on a start edge only
//   data_result [WIDTH]        : low product bits or quotient
//   data_exception             : overflow / divide-by-zero flag
//   data_resultRDY             : one-cycle result-valid pulse
//   busy                       : operation in flight
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]  cnt;
  logic [2*W:0]   prod;
  logic [W-1:0]   mcand;
  logic [W+1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvsr;
  logic           neg;
  logic           bzero;

  logic           start;
  logic           run;
  logic           last;
  logic           fast_done;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  logic [W-1:0]   acc;
  logic [W:0]     bsum;
  logic [2*W:0]   prod_n;
  logic [W+1:0]   rsh;
  logic [W+1:0]   rem_n;
  logic [W-1:0]   quo_n;

  assign start = ctrl_MULT | ctrl_DIV;
  assign run   = (state == MUL) || (state == DIV);
  assign last  = (cnt == CW'(ITERS)) || fast_done;

  // Magnitudes as unsigned; -2^(W-1) maps onto 2^(W-1).
  assign a_mag = data_operandA[W-1] ? -data_operandA
                                    : data_operandA;
  assign b_mag = data_operandB[W-1] ? -data_operandB
                                    : data_operandB;

`ifdef MULTDIV_FAST_EXC_EN
  logic fast;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fast <= 1'b0;
    end else if (start) begin
      if (ctrl_MULT)
        fast <= (data_operandA == '0) ||
                (data_operandB == '0);
      else
        fast <= (data_operandB == '0);
    end else if (!run) begin
      fast <= 1'b0;
    end
  end

  assign fast_done = run && fast;
`else
  assign fast_done = 1'b0;
`endif

  // Booth step. The add is done one bit wider so that
  // subtracting the most negative multiplicand keeps its sign;
  // the extra bit is consumed by the arithmetic shift.
  assign acc = prod[2*W:W+1];

  always_comb begin
    bsum = {acc[W-1], acc};
    unique case (1'b1)
      (prod[1:0] == 2'b01):
        bsum = {acc[W-1], acc} + {mcand[W-1], mcand};
      (prod[1:0] == 2'b10):
        bsum = {acc[W-1], acc} - {mcand[W-1], mcand};
      default: ;
    endcase
  end

  assign prod_n = {bsum, prod[W:1]};

  // Non-restoring step on magnitudes; the quotient bit is the
  // sign of the new partial remainder, so no final fix-up is
  // needed for the quotient.
  assign rsh   = {rem[W:0], quo[W-1]};
  assign rem_n = rem[W+1] ? rsh + {2'b00, dvsr}
                          : rsh - {2'b00, dvsr};
  assign quo_n = {quo[W-2:0], ~rem_n[W+1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = IDLE;
      MUL, DIV: if (last) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (ctrl_MULT)
      state_n = MUL;
    else if (ctrl_DIV)
      state_n = DIV;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      prod           <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      neg            <= 1'b0;
      bzero          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt            <= '0;
      prod           <= {{W{1'b0}}, data_operandB, 1'b0};
      mcand          <= data_operandA;
      rem            <= '0;
      quo            <= a_mag;
      dvsr           <= b_mag;
      neg            <= data_operandA[W-1] ^
                        data_operandB[W-1];
      bzero          <= (data_operandB == '0);
      data_exception <= 1'b0;
    end else if (run) begin
      if (fast_done) begin
        data_result    <= '0;
        data_exception <= (state == DIV);
      end else if (last) begin
        if (state == MUL) begin
          data_result    <= prod[W:1];
          data_exception <= prod[2*W:W+1] != {W{prod[W]}};
        end else if (bzero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= neg ? -quo : quo;
          // Only +2^(W-1) cannot be represented.
          data_exception <= ~neg & quo[W-1];
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (state == MUL) begin
          prod <= prod_n;
        end else begin
          rem <= rem_n;
          quo <= quo_n;
        end
      end
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = run && (cnt != '0);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table, hand-written
// corner sequences and random operations against a reference model.
module tb_multdiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  multdiv_unit #(.WIDTH(W), .ITERS(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    string       nm;
    bit          mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic void model(input bit mul,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic e);
    longint p;
    int     q;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 0) begin
      r = 0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input bit mul,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULTDIV_FAST_EXC_EN
    if (mul ? (a == 0 || b == 0) : (b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge; the next posedge is edge 0.
  // Cycle k is sampled at the negedge after edge k.
  task automatic run_op(input bit mul, input bit dv,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] r,
                        output logic e,
                        output int lat,
                        output int nbusy,
                        output int nrdy,
                        output logic [31:0] held);
    ctrl_MULT = mul;
    ctrl_DIV = dv;
    data_operandA = a;
    data_operandB = b;
    lat = -1;
    nbusy = 0;
    nrdy = 0;
    r = 'x;
    e = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      nbusy += int'(busy);
      if (data_resultRDY) begin
        nrdy++;
        if (lat < 0) begin
          lat = k;
          r = data_result;
          e = data_exception;
        end
      end
    end
    held = data_result;
  endtask

  task automatic check_op(input string nm, input bit mul,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] er,
                          input logic ee);
    logic [31:0] r, held;
    logic        e;
    int          lat, nb, nr, el;
    el = exp_lat(mul, a, b);
    run_op(mul, !mul, a, b, r, e, lat, nb, nr, held);
    chk({nm, "_res"}, r, er);
    chk({nm, "_exc"}, e, ee);
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_busy"}, nb, el - 1);
    chk({nm, "_nrdy"}, nr, 1);
    chk({nm, "_hold"}, held, er);
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] r, held, er, a, b;
    logic        e, ee;
    int          lat, nb, nr, n;
    int          rq[$];
    logic [31:0] rv[$];
    bit          mul;

    vt.push_back('{"mul7xm3", 1, 32'd7, 32'hFFFF_FFFD,
                   32'hFFFF_FFEB, 1'b0});
    vt.push_back('{"mulovf", 1, 32'h0001_0000, 32'h0001_0000,
                   32'h0, 1'b1});
    vt.push_back('{"divm100", 0, 32'hFFFF_FF9C, 32'd7,
                   32'hFFFF_FFF2, 1'b0});
    vt.push_back('{"divovf", 0, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 1'b1});
    vt.push_back('{"div0", 0, 32'd5, 32'd0, 32'h0, 1'b1});
    vt.push_back('{"mulminmin", 1, 32'h8000_0000, 32'h8000_0000,
                   32'h0, 1'b1});
    vt.push_back('{"mulmin1", 1, 32'h8000_0000, 32'd1,
                   32'h8000_0000, 1'b0});
    vt.push_back('{"mulm1m1", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'd1, 1'b0});
    vt.push_back('{"mulminm1", 1, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 1'b1});
    vt.push_back('{"mulneg31", 1, 32'h0000_8000, 32'hFFFF_0000,
                   32'h8000_0000, 1'b0});
    vt.push_back('{"mulzero", 1, 32'd0, 32'd12345,
                   32'h0, 1'b0});
    vt.push_back('{"divmax", 0, 32'h7FFF_FFFF, 32'd1,
                   32'h7FFF_FFFF, 1'b0});
    vt.push_back('{"divm7p2", 0, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFD, 1'b0});
    vt.push_back('{"div7m2", 0, 32'd7, 32'hFFFF_FFFE,
                   32'hFFFF_FFFD, 1'b0});
    vt.push_back('{"div0by5", 0, 32'd0, 32'd5, 32'h0, 1'b0});
    vt.push_back('{"divmin2", 0, 32'h8000_0000, 32'd2,
                   32'hC000_0000, 1'b0});

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_res", data_result, 32'h0);
    chk("rst_exc", data_exception, 1'b0);
    chk("rst_rdy", data_resultRDY, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    foreach (vt[i])
      check_op(vt[i].nm, vt[i].mul, vt[i].a, vt[i].b,
               vt[i].r, vt[i].e);

    // Both strobes: multiply wins.
    run_op(1, 1, 32'd6, 32'd2, r, e, lat, nb, nr, held);
    chk("both_res", r, 32'd12);
    chk("both_lat", lat, 33);

    // Restart: only the second operation reports.
    rq.delete();
    rv.delete();
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      if (k == 9) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd4;
      end
      if (data_resultRDY) begin
        rq.push_back(k);
        rv.push_back(data_result);
      end
    end
    chk("restart_nrdy", rq.size(), 1);
    n = (rq.size() > 0) ? rq[0] : -1;
    chk("restart_cyc", n, 43);
    er = (rv.size() > 0) ? rv[0] : 32'hDEAD_BEEF;
    chk("restart_res", er, 32'd5);

    // Exception clears at the next start, result holds.
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF,
           r, e, lat, nb, nr, held);
    chk("excset", e, 1'b1);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    chk("excclr_exc", data_exception, 1'b0);
    chk("excclr_res", data_result, 32'h8000_0000);
    repeat (40) @(negedge clock);
    chk("excclr_new", data_result, 32'd6);

    // Random operations against the model.
    for (int i = 0; i < 30; i++) begin
      mul = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) begin
        a = 32'($urandom_range(0, 2000)) - 32'd1000;
        b = 32'($urandom_range(0, 2000)) - 32'd1000;
      end
      if (i % 7 == 3) b = 0;
      if (i % 9 == 5) a = 0;
      model(mul, a, b, er, ee);
      check_op($sformatf("rnd%0d", i), mul, a, b, er, ee);
    end

    // Strobe during DONE starts the next operation.
    rq.delete();
    rv.delete();
    ctrl_MULT = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    for (int k = 0; k < 75; k++) begin
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        rq.push_back(k);
        rv.push_back(data_result);
      end
      if (k == 33) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd10;
      end
    end
    chk("done_nrdy", rq.size(), 2);
    n = (rq.size() > 0) ? rq[0] : -1;
    chk("done_cyc0", n, 33);
    n = (rq.size() > 1) ? rq[1] : -1;
    chk("done_cyc1", n, 67);
    er = (rv.size() > 0) ? rv[0] : 32'hDEAD_BEEF;
    chk("done_res0", er, 32'd25);
    er = (rv.size() > 1) ? rv[1] : 32'hDEAD_BEEF;
    chk("done_res1", er, 32'd10);

    // Asynchronous reset mid-operation.
    ctrl_MULT = 1'b1;
    data_operandA = 32'd123;
    data_operandB = 32'd456;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
    end
    chk("mid_busy_pre", busy, 1'b1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_res", data_result, 32'h0);
    chk("mid_exc", data_exception, 1'b0);
    chk("mid_rdy", data_resultRDY, 1'b0);
    chk("mid_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    nb = 0;
    repeat (45) begin
      @(posedge clock);
      @(negedge clock);
      n += int'(data_resultRDY);
      nb += int'(busy);
    end
    chk("mid_nordy", n, 0);
    chk("mid_nobusy", nb, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
